// File: rtl/note_hit_judge_if.sv
// Signal bundle between the note renderer / player buttons and the hit judge.
// The master side is the renderer and buttons. The slave side is the judge.
interface note_hit_judge_if #(
    parameter int LANES = 3,
    parameter int SLOTS = 5,
    parameter int POS_W = 10
);
    logic [LANES-1:0]             btn;
    logic [LANES*SLOTS-1:0]       active;
    logic [LANES*SLOTS*POS_W-1:0] pos;
    logic [LANES*SLOTS-1:0]       clear;
    logic [15:0]                  score_bcd;
    logic [7:0]                   combo;
    logic                         hit_pulse;
    logic                         miss_pulse;
    logic [1:0]                   last_judge;

    modport master (
        output btn, active, pos,
        input  clear, score_bcd, combo, hit_pulse, miss_pulse, last_judge
    );

    modport slave (
        input  btn, active, pos,
        output clear, score_bcd, combo, hit_pulse, miss_pulse, last_judge
    );
endinterface

// File: rtl/note_hit_judge.sv
// Judges lane button presses against the hit bar and clears hit notes.
// It also detects notes that fall past the bar and keeps a BCD score and a combo count.
module note_hit_judge #(
    parameter int LANES       = 3,
    parameter int SLOTS       = 5,
    parameter int POS_W       = 10,
    parameter int HIT_TOP     = 410,
    parameter int HIT_BOT     = 450,
    parameter int PERFECT_C   = 430,
    parameter int PERFECT_TOL = 5
) (
    input  logic             clk,
    input  logic             reset,
    note_hit_judge_if.slave  bus
);
    localparam int NS     = LANES * SLOTS;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SLOT_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [POS_W-1:0] TOP = POS_W'(HIT_TOP);
    localparam logic [POS_W-1:0] BOT = POS_W'(HIT_BOT);
    localparam logic [POS_W-1:0] PC  = POS_W'(PERFECT_C);
    localparam logic [POS_W-1:0] TOL = POS_W'(PERFECT_TOL);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
    typedef enum logic [1:0] {
        J_NONE    = 2'b00,
        J_GOOD    = 2'b01,
        J_PERFECT = 2'b10,
        J_MISS    = 2'b11
    } judge_t;

    state_t            state, state_next;
    judge_t            res_q, last_q;
    logic [LANES-1:0]  btn_q, pending, btn_edge, pend_clr;
    logic [NS-1:0]     judged, judged_set;
    logic [LANE_W-1:0] lane_q, pend_lane;
    logic [SLOT_W-1:0] slot_q, late_slot, scan_slot;
    logic              pend_any, late_found, scan_found, scan_perfect;
    logic              late_take, lane_load, apply_hit, late_q;
    logic [15:0]       score_q, score_next;
    logic [7:0]        combo_q;

    assign btn_edge  = bus.btn & ~btn_q;
    assign apply_hit = (state == APPLY) && ((res_q == J_GOOD) || (res_q == J_PERFECT));

    // Lowest pending lane, lowest late slot and lowest in-window slot of the latched lane.
    // The loops run from high index to low so that the last write is the lowest index.
    always_comb begin
        logic [POS_W-1:0] p;
        logic [POS_W-1:0] diff;
        p            = '0;
        diff         = '0;
        pend_any     = 1'b0;
        pend_lane    = '0;
        late_found   = 1'b0;
        late_slot    = '0;
        scan_found   = 1'b0;
        scan_slot    = '0;
        scan_perfect = 1'b0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (pending[l]) begin
                pend_any  = 1'b1;
                pend_lane = LANE_W'(l);
            end
        end
        for (int i = NS - 1; i >= 0; i--) begin
            p = bus.pos[i*POS_W +: POS_W];
            if (bus.active[i] && !judged[i] && (p > BOT)) begin
                late_found = 1'b1;
                late_slot  = SLOT_W'(i);
            end
        end
        for (int l = LANES - 1; l >= 0; l--) begin
            for (int k = SLOTS - 1; k >= 0; k--) begin
                p = bus.pos[(l*SLOTS + k)*POS_W +: POS_W];
                if ((LANE_W'(l) == lane_q) && bus.active[l*SLOTS + k] &&
                    !judged[l*SLOTS + k] && (p >= TOP) && (p <= BOT)) begin
                    diff         = (p >= PC) ? (p - PC) : (PC - p);
                    scan_found   = 1'b1;
                    scan_slot    = SLOT_W'(l*SLOTS + k);
                    scan_perfect = (diff <= TOL);
                end
            end
        end
    end

    // Ripple BCD add of 0, 1 or 2. A carry out of the thousands digit pins the score at 9999.
    always_comb begin
        logic [4:0] s;
        logic [1:0] c;
        s          = '0;
        c          = (res_q == J_PERFECT) ? 2'd2 : ((res_q == J_GOOD) ? 2'd1 : 2'd0);
        score_next = score_q;
        for (int d = 0; d < 4; d++) begin
            s = {1'b0, score_q[d*4 +: 4]} + {3'b000, c};
            if (s > 5'd9) begin
                score_next[d*4 +: 4] = 4'(s - 5'd10);
                c                    = 2'd1;
            end else begin
                score_next[d*4 +: 4] = s[3:0];
                c                    = 2'd0;
            end
        end
        if (c != 2'd0) begin
            score_next = 16'h9999;
        end
    end

    always_comb begin
        state_next = state;
        pend_clr   = '0;
        judged_set = '0;
        late_take  = 1'b0;
        lane_load  = 1'b0;
        case (state)
            IDLE: begin
                if (pend_any) begin
                    state_next = SCAN;
                    lane_load  = 1'b1;
                end else if (late_found) begin
                    late_take             = 1'b1;
                    judged_set[late_slot] = 1'b1;
                end
            end
            SCAN: begin
                state_next       = APPLY;
                pend_clr[lane_q] = 1'b1;
            end
            APPLY: begin
                state_next = IDLE;
                if (apply_hit) begin
                    judged_set[slot_q] = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An edge on a lane that is already pending is dropped. A judged bit is cleared by an inactive slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            btn_q   <= '0;
            pending <= '0;
            judged  <= '0;
            lane_q  <= '0;
            slot_q  <= '0;
            res_q   <= J_NONE;
            last_q  <= J_NONE;
            late_q  <= 1'b0;
            score_q <= '0;
            combo_q <= '0;
        end else begin
            state   <= state_next;
            btn_q   <= bus.btn;
            pending <= (pending & ~pend_clr) | (btn_edge & ~pending);
            judged  <= (judged | judged_set) & bus.active;
            late_q  <= late_take;
            if (lane_load) begin
                lane_q <= pend_lane;
            end
            if (state == SCAN) begin
                slot_q <= scan_slot;
                res_q  <= scan_found ? (scan_perfect ? J_PERFECT : J_GOOD) : J_MISS;
            end
            if (state == APPLY) begin
                last_q <= res_q;
                if (apply_hit) begin
                    score_q <= score_next;
                    combo_q <= (combo_q == 8'd255) ? 8'd255 : combo_q + 8'd1;
                end else begin
                    combo_q <= '0;
                end
            end else if (late_take) begin
                last_q  <= J_MISS;
                combo_q <= '0;
            end
        end
    end

    assign bus.clear      = apply_hit ? (NS'(1) << slot_q) : '0;
    assign bus.hit_pulse  = apply_hit;
    assign bus.miss_pulse = late_q | ((state == APPLY) && (res_q == J_MISS));
    assign bus.score_bcd  = score_q;
    assign bus.combo      = combo_q;
    assign bus.last_judge = last_q;
endmodule
